// File: rtl/circle_point_stream_if.sv
// Point stream from the circle rasteriser to the framebuffer write stage.
// Valid/ready: a point transfers on a rising clock edge where _valid && _ready;
// once _valid is high, it and the point stay put until that transfer happens.
interface circle_point_stream_if #(
    parameter int WIDTH = 32
);
    logic                    _valid;
    logic                    _ready;
    logic signed [WIDTH-1:0] _out0;
    logic signed [WIDTH-1:0] _out1;

    modport master (output _valid, output _out0, output _out1, input _ready);
    modport slave  (input _valid, input _out0, input _out1, output _ready);
endinterface

// File: rtl/circle_point_stream.sv
// Midpoint-circle rasteriser: streams the 8-way symmetric points of each (x,y)
// step, with per-index masking, optional duplicate suppression and backpressure.
module circle_point_stream #(
    parameter int WIDTH = 32,
    parameter int DW    = WIDTH + 4
) (
    input  logic                    _clock,
    input  logic                    _reset_n,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] s_x,
    input  logic signed [WIDTH-1:0] s_y,
    input  logic signed [WIDTH-1:0] radius,
    input  logic [7:0]              octant_mask,
    input  logic                    dedup,
    circle_point_stream_if.master   pt,
    output logic                    _busy,
    output logic                    _done,
    output logic [1:0]              state_o
);
    typedef enum logic [1:0] {IDLE, EMIT, UPDATE, DONE} state_t;

    localparam logic signed [WIDTH-1:0] ONE_W  = 1;
    localparam logic signed [DW-1:0]    ZERO_D = '0;
    localparam logic signed [DW-1:0]    C3     = 3;
    localparam logic signed [DW-1:0]    C6     = 6;
    localparam logic signed [DW-1:0]    C10    = 10;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] sx_q, sx_d, sy_q, sy_d, x_q, x_d, y_q, y_d;
    logic signed [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
    logic signed [DW-1:0]    d_q, d_d;
    logic [7:0]              mask_q, mask_d, pend_q, pend_d;
    logic                    dedup_q, dedup_d, valid_q, valid_d;
    logic                    done_q, done_d, busy_q, busy_d;
    logic [2:0]              cur_idx, nxt_idx;
    logic signed [DW-1:0]    r_ext, x_ext, yn_ext;
    logic signed [WIDTH-1:0] y_new, x_new;

    function automatic logic [7:0] set_enables(input logic [7:0] m, input logic dd,
                                               input logic signed [WIDTH-1:0] x,
                                               input logic signed [WIDTH-1:0] y);
        logic [7:0] sup;
        sup = '0;
        if (dd) begin
            if (x == '0) sup = sup | 8'b1010_1100;
            if (y == '0) sup = sup | 8'b1100_1010;
            if (x == y)  sup = sup | 8'b1111_0000;
        end
        return m & ~sup;
    endfunction

    function automatic logic [2:0] lowest(input logic [7:0] p);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) if (p[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] point_at(input logic [2:0] k,
                                                    input logic signed [WIDTH-1:0] cx,
                                                    input logic signed [WIDTH-1:0] cy,
                                                    input logic signed [WIDTH-1:0] px,
                                                    input logic signed [WIDTH-1:0] py);
        case (k)
            3'd0:    return {cx + px, cy + py};
            3'd1:    return {cx + px, cy - py};
            3'd2:    return {cx - px, cy + py};
            3'd3:    return {cx - px, cy - py};
            3'd4:    return {cx + py, cy + px};
            3'd5:    return {cx + py, cy - px};
            3'd6:    return {cx - py, cy + px};
            default: return {cx - py, cy - px};
        endcase
    endfunction

    assign cur_idx = lowest(pend_q);
    assign r_ext   = {{(DW-WIDTH){radius[WIDTH-1]}}, radius};
    assign x_ext   = {{(DW-WIDTH){x_q[WIDTH-1]}}, x_q};
    assign y_new   = (d_q > ZERO_D) ? (y_q - ONE_W) : y_q;
    assign yn_ext  = {{(DW-WIDTH){y_new[WIDTH-1]}}, y_new};
    assign x_new   = x_q + ONE_W;

    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        x_d     = x_q;
        y_d     = y_q;
        d_d     = d_q;
        mask_d  = mask_q;
        dedup_d = dedup_q;
        pend_d  = pend_q;
        done_d  = done_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE, DONE: begin
                if (_start) begin
                    sx_d    = s_x;
                    sy_d    = s_y;
                    mask_d  = octant_mask;
                    dedup_d = dedup;
                    x_d     = '0;
                    y_d     = radius;
                    d_d     = C3 - (r_ext <<< 1);
                    pend_d  = set_enables(octant_mask, dedup, '0, radius);
                    if (radius[WIDTH-1]) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pend_d  = '0;
                    end else begin
                        state_d = EMIT;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (!valid_q) begin
                    state_d = UPDATE;
                end else if (pt._ready) begin
                    pend_d = pend_q & ~(8'b1 << cur_idx);
                    if (pend_d == '0) state_d = UPDATE;
                end
            end
            UPDATE: begin
                // Decision term uses the pre-increment x and the already-stepped y.
                if (d_q > ZERO_D) d_d = d_q + ((x_ext - yn_ext) <<< 2) + C10;
                else              d_d = d_q + (x_ext <<< 2) + C6;
                x_d = x_new;
                y_d = y_new;
                if (y_new >= x_new) begin
                    state_d = EMIT;
                    pend_d  = set_enables(mask_q, dedup_q, x_new, y_new);
                end else begin
                    state_d = DONE;
                    pend_d  = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are computed from next-state values so they are registered.
        valid_d = (state_d == EMIT) && (pend_d != '0);
        nxt_idx = lowest(pend_d);
        if (valid_d) {out0_d, out1_d} = point_at(nxt_idx, sx_d, sy_d, x_d, y_d);
        else         {out0_d, out1_d} = {out0_q, out1_q};
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_q <= IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            d_q     <= '0;
            mask_q  <= '0;
            dedup_q <= 1'b0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            out0_q  <= '0;
            out1_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            d_q     <= d_d;
            mask_q  <= mask_d;
            dedup_q <= dedup_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign pt._valid = valid_q;
    assign pt._out0  = out0_q;
    assign pt._out1  = out1_q;
    assign _busy     = busy_q;
    assign _done     = done_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_circle_point_stream.sv
// Directed bench for circle_point_stream: point-list model, per-cycle stream
// compare with stall stability, and literal pins on key points and timing.
module tb_circle_point_stream;
    localparam int W = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic signed [W-1:0] sx = '0, sy = '0, rad = '0;
    logic [7:0]          mask = '0;
    logic                dd = 1'b0;
    logic                rdy = 1'b1;
    logic                busy, done;
    logic [1:0]          state_dbg;

    circle_point_stream_if #(.WIDTH(W)) bus ();
    assign bus._ready = rdy;

    circle_point_stream #(.WIDTH(W)) dut (
        ._clock(clk), ._reset_n(rst_n), ._start(start),
        .s_x(sx), .s_y(sy), .radius(rad), .octant_mask(mask), .dedup(dd),
        .pt(bus.master), ._busy(busy), ._done(done), .state_o(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // scoreboard
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] acc_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected point list straight from the midpoint rules, in plain ints.
    task automatic model_push(input int cx, input int cy, input int r,
                              input logic [7:0] m, input logic dup);
        int x, y, d, px, py;
        bit skip;
        if (r < 0) return;
        x = 0; y = r; d = 3 - 2 * r;
        while (y >= x) begin
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: begin px = cx + x; py = cy + y; end
                    1: begin px = cx + x; py = cy - y; end
                    2: begin px = cx - x; py = cy + y; end
                    3: begin px = cx - x; py = cy - y; end
                    4: begin px = cx + y; py = cy + x; end
                    5: begin px = cx + y; py = cy - x; end
                    6: begin px = cx - y; py = cy + x; end
                    default: begin px = cx - y; py = cy - x; end
                endcase
                skip = dup && ((x == 0 && k inside {2, 3, 5, 7}) ||
                               (y == 0 && k inside {1, 3, 6, 7}) ||
                               (x == y && k >= 4));
                if (m[k] && !skip) exp_q.push_back({px, py});
            end
            if (d > 0) begin y--; d = d + 4 * (x - y) + 10; end
            else d = d + 4 * x + 6;
            x++;
        end
    endtask

    // compare process
    logic           stall_q = 1'b0;
    logic [2*W-1:0] held_q = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", {{(2*W-1){1'b0}}, bus._valid}, 1);
                check("stall_point", {bus._out0, bus._out1}, held_q);
            end
            if (bus._valid && bus._ready) begin
                acc_q.push_back({bus._out0, bus._out1});
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_point: got %h expected none", {bus._out0, bus._out1});
                end else begin
                    check("point", {bus._out0, bus._out1}, exp_q.pop_front());
                end
            end
            stall_q <= bus._valid && !bus._ready;
            held_q  <= {bus._out0, bus._out1};
        end
    end

    // driver
    task automatic run_circle(input string name, input int cx, input int cy, input int r,
                              input logic [7:0] m, input logic dup, input bit toggle,
                              input int exp_n);
        bit fin;
        exp_q.delete();
        acc_q.delete();
        model_push(cx, cy, r, m, dup);
        check({name, "_model_n"}, exp_q.size(), exp_n);
        sx = cx; sy = cy; rad = r; mask = m; dd = dup; rdy = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_first_valid"}, {{(2*W-1){1'b0}}, bus._valid}, (exp_n > 0) ? 1 : 0);
        check({name, "_busy_hi"}, {{(2*W-1){1'b0}}, busy}, 1);
        fin = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (toggle) rdy = ~cyc[0];
            // a start while busy must be ignored
            if (toggle && cyc == 2) begin start = 1'b1; rad = 7; end
            else start = 1'b0;
            @(posedge clk); #1;
            fin = done;
        end
        start = 1'b0;
        rdy = 1'b1;
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got done=0 expected done=1", name);
        end
        check({name, "_count"}, acc_q.size(), exp_n);
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_busy_lo"}, {{(2*W-1){1'b0}}, busy}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {{(2*W-1){1'b0}}, bus._valid}, 0);
        check("rst_out", {bus._out0, bus._out1}, 0);
        check("rst_busy_done", {{(2*W-2){1'b0}}, busy, done}, 0);
        check("rst_state", {{(2*W-2){1'b0}}, state_dbg}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // negative radius: no points, done one cycle after start
        exp_q.delete();
        sx = 0; sy = 0; rad = -3; mask = 8'hFF; dd = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("neg_done", {{(2*W-1){1'b0}}, done}, 1);
        check("neg_busy", {{(2*W-1){1'b0}}, busy}, 0);
        repeat (3) begin
            check("neg_valid", {{(2*W-1){1'b0}}, bus._valid}, 0);
            @(posedge clk); #1;
        end

        run_circle("r0_dedup", 5, 5, 0, 8'hFF, 1'b1, 1'b0, 1);
        check("r0_dedup_pt", acc_q[0], {32'd5, 32'd5});

        run_circle("r0_all", 5, 5, 0, 8'hFF, 1'b0, 1'b0, 8);
        check("r0_all_pt7", acc_q[7], {32'd5, 32'd5});

        run_circle("r2_dedup", 0, 0, 2, 8'hFF, 1'b1, 1'b0, 12);
        check("r2_dedup_pt1", acc_q[1], {32'h0, 32'hFFFF_FFFE});
        check("r2_dedup_pt3", acc_q[3], {32'hFFFF_FFFE, 32'h0});
        check("r2_dedup_pt4", acc_q[4], {32'd1, 32'd2});
        check("r2_dedup_pt11", acc_q[11], {32'hFFFF_FFFE, 32'hFFFF_FFFF});

        run_circle("r2_all", 0, 0, 2, 8'hFF, 1'b0, 1'b0, 16);

        run_circle("r2_toggle", 0, 0, 2, 8'h01, 1'b1, 1'b1, 2);
        check("r2_toggle_pt0", acc_q[0], {32'd0, 32'd2});
        check("r2_toggle_pt1", acc_q[1], {32'd1, 32'd2});

        run_circle("wrap", 32'h7FFF_FFFF, 0, 1, 8'hFF, 1'b1, 1'b0, 4);
        check("wrap_pt2", acc_q[2], {32'h8000_0000, 32'h0});

        // reset in the middle of a radius-10 stream
        exp_q.delete();
        acc_q.delete();
        model_push(0, 0, 10, 8'hFF, 1'b1);
        sx = 0; sy = 0; rad = 10; mask = 8'hFF; dd = 1'b1; rdy = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {{(2*W-1){1'b0}}, bus._valid}, 0);
        check("midrst_out", {bus._out0, bus._out1}, 0);
        check("midrst_busy_done", {{(2*W-2){1'b0}}, busy, done}, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;

        run_circle("r10", 0, 0, 10, 8'hFF, 1'b1, 1'b0, 56);
        check("r10_pt0", acc_q[0], {32'd0, 32'd10});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/circle_point_stream.md
# circle_point_stream

Parametrised midpoint-circle rasteriser that turns a centre and radius into a stream of pixel coordinates, one point per accepted handshake. It is the successor to the fixed 32-bit generated circle/line drawer. It adds a configurable coordinate width, a valid/ready output handshake with backpressure, a per-octant enable mask, an optional duplicate-suppression mode and an asynchronous reset. It sits between the draw-command decoder and the framebuffer write stage.

## Interface
- WIDTH, 32: coordinate width in bits; all coordinate ports are signed WIDTH.
- DW, WIDTH+4: internal decision-variable width, signed.
- Reset is asynchronous and active-low; there is one clock.
- _clock  in  1  rising-edge clock.
- _reset_n  in  1  asynchronous active-low reset.
- _start  in  1  launch a circle; sampled only in IDLE or DONE.
- s_x, s_y  in  WIDTH  centre, signed; latched on _start.
- radius  in  WIDTH  radius, signed; latched on _start.
- octant_mask  in  8  enables point index k (bit k); latched on _start.
- dedup  in  1  suppress within-set duplicate points; latched on _start.
- _ready  in  1  downstream accepts the point this cycle.
- _valid  out  1  _out0/_out1 hold a valid point.
- _out0, _out1  out  WIDTH  point x and point y.
- _busy  out  1  high from the cycle after _start until _done rises.
- _done  out  1  level; high after the last point is accepted, until the next _start.

## Operation
- FSM states: IDLE, EMIT, UPDATE, DONE.
- _start in IDLE or DONE:
  - latch the inputs; x=0, y=radius, d=3-2*radius; clear _done.
  - If radius<0, go to DONE with no points; otherwise go to EMIT.
- Point set for the current (x,y), index order 0..7:
  - 0 (sx+x, sy+y), 1 (sx+x, sy-y), 2 (sx-x, sy+y), 3 (sx-x, sy-y)
  - 4 (sx+y, sy+x), 5 (sx+y, sy-x), 6 (sx-y, sy+x), 7 (sx-y, sy-x)
- Index k is emitted only if octant_mask[k] is set and k is not suppressed. When dedup=1, suppression is:
  - x==0: skip 2, 3, 5, 7.
  - y==0: skip 1, 3, 6, 7.
  - x==y: skip 4..7.
  - Rules combine by OR.
- EMIT: present the lowest pending index. Advance on _valid&&_ready. After the last pending index is accepted, go to UPDATE. A set with no pending indices goes straight to UPDATE.
- UPDATE (single cycle, _valid low), using pre-increment x:
  - If d>0: y=y-1, then d=d+4*(x-y)+10 using the new y.
  - Otherwise: d=d+4*x+6.
  - Then x=x+1.
  - If the new y>=x, go to EMIT; otherwise go to DONE and set _done.
- Arithmetic:
  - Output sums wrap modulo 2^WIDTH and are not saturated.
  - d is held in DW bits and never overflows for radius < 2^(WIDTH-2).
- _start while _busy is ignored.

## Timing
- Reset values: _valid=0, _done=0, _busy=0, _out0=0, _out1=0, state IDLE. Reset mid-circle aborts immediately and drops any pending point.
- Latency: first _valid is asserted 1 cycle after the _start edge.
- With _ready held high: one point per cycle within a set, plus one UPDATE cycle per set.
- Backpressure: while _valid && !_ready, _out0, _out1 and _valid stay stable. _valid never drops without acceptance.
- Handshake: _ready is ignored while _valid=0, and there is no combinational path from _ready to _valid.
- _done and _busy:
  - _done rises 1 cycle after the final UPDATE (or after _start when radius<0); _busy falls in the same cycle.
- _start and acceptance: _start in the same cycle as the acceptance of the final point is ignored (the block is still busy).

## Test plan
- radius=0, s=(5,5), mask=FF, dedup=1 -> exactly one point (5,5), then _done.
- radius=0, s=(5,5), mask=FF, dedup=0 -> eight points, each (5,5).
- radius=2, s=(0,0), mask=FF, dedup=1 -> 12 points:
  - (0,2), (0,-2), (2,0), (-2,0)
  - then the (1,2) set: (1,2), (1,-2), (-1,2), (-1,-2), (2,1), (2,-1), (-2,1), (-2,-1)
  - then _done.
  - Same circle with dedup=0 -> 16 points.
- radius=2, mask=0x01, _ready toggling 1/0 every cycle -> points (0,2), (1,2) only. Outputs stay stable during every stall; no point is lost or repeated.
- radius=-3 -> no _valid; _done rises 1 cycle after _start.
- radius=10: assert _reset_n=0 mid-stream -> all outputs read 0 asynchronously. A new _start after release restarts from (0,10) with no leftover points.
